fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Single-clock write-port arbiter for the asynchronous FIFO's write side. It shares the FIFO write port between two requesters: register-file read data (one byte) and ALU results (two bytes, written low byte first as an atomic pair). It buffers one request per source, grants the port round-robin, and gates every write on `FULL`. It sits in the `W_CLK` domain between the system controller's result paths and the FIFO's `W_INC`/`WR_DATA` inputs.

## Interface
- `DATA_WIDTH`, from `parameters_pkg`: FIFO word width. The ALU result is `2*DATA_WIDTH` bits wide.
- `CLK`, input, 1: write-domain clock. Connects to `W_CLK`.
- `RST`, input, 1: reset. Synchronous, active-low.
- `RF_RD_DATA`, input, `DATA_WIDTH`: register-file read byte.
- `RF_RD_VLD`, input, 1: single-cycle valid for `RF_RD_DATA`.
- `ALU_OUT`, input, `2*DATA_WIDTH`: ALU result.
- `ALU_OUT_VLD`, input, 1: single-cycle valid for `ALU_OUT`.
- `FULL`, input, 1: FIFO full flag, already synchronised to the write domain.
- `W_INC`, output, 1: FIFO write strobe.
- `WR_DATA`, output, `DATA_WIDTH`: FIFO write data.
- `RF_BUSY`, output, 1: the register-file slot holds an unsent byte.
- `ALU_BUSY`, output, 1: the ALU slot holds an unsent result.
- `DROP_CNT`, output, 8: count of lost requests. Present only when the configuration macro is defined.

## Operation
- **Request slots.** Each source has one holding register plus a pending flag.
  - A valid pulse captures the data and sets pending.
  - Pending is cleared at the edge where the source's final byte is written.
  - If a valid arrives on that same clear edge, the new data is captured and pending stays 1.
  - If a valid arrives while pending is 1 and no clear happens that edge, the new data is discarded, the held data is unchanged, and the request counts as dropped.
- **FSM states.** `IDLE`, `WR_RF`, `WR_ALU_LO`, `WR_ALU_HI`.
  - `IDLE`: if only one slot is pending, go to `WR_RF` or `WR_ALU_LO` accordingly. If both are pending, grant the source that was not served last. The `last` bit resets to ALU, so RF wins the first tie.
  - `WR_RF`: hold while `FULL=1`. Otherwise write one byte and return to `IDLE`, setting `last`=RF.
  - `WR_ALU_LO`: hold while `FULL=1`. Otherwise write `ALU_OUT[DATA_WIDTH-1:0]` and go to `WR_ALU_HI`.
  - `WR_ALU_HI`: hold while `FULL=1`. Otherwise write the upper byte, go to `IDLE`, and set `last`=ALU.
  - No RF byte is ever written between the LO and HI bytes of one ALU result.
- **Outputs.**
  - `W_INC` = (state is `WR_*`) AND NOT `FULL`. This is the only combinational path from an input to an output.
  - `WR_DATA` is a function of the current state and the slot register only.
  - `RF_BUSY` and `ALU_BUSY` equal the pending flags.
- **Reset.**
  - Reset values: state=`IDLE`, both pending=0, `last`=ALU, slot data=0, `W_INC`=0, `WR_DATA`=0, `DROP_CNT`=0.
  - Reset asserted mid-pair discards the remaining HI byte. The FIFO is reset in the same domain, so no partial pair can survive.

## Timing
- A valid sampled at edge k sets pending at k. The FSM leaves `IDLE` at edge k+1. `W_INC` is high in cycle k+1..k+2 and the write occurs at edge k+2. First-byte latency is 2 clocks.
- An ALU pair with `FULL=0` is written on two consecutive edges, k+2 and k+3.
- Back-to-back grants pass through `IDLE` for one cycle, so sustained throughput is 1 byte per 2 clocks for RF and 2 bytes per 3 clocks for ALU.
- When `FULL` rises, `W_INC` drops in the same cycle and no write is lost. The state is held, and writing resumes on the first edge with `FULL=0`.
- Valids arriving while the FSM is in any state are captured per the slot rules.

## Configuration
- `FIFO_ARB_DROP_CNT_EN` defined: the `DROP_CNT` port and register exist.
  - It increments once per dropped request and saturates at 255.
  - If both sources drop on the same edge, it increments by 2, still saturating.
- Not defined: the port and register are absent. Drops are silent and all other behaviour is identical.

## Structure
- Add typedef enum `arb_state_e` {`IDLE`, `WR_RF`, `WR_ALU_LO`, `WR_ALU_HI`} to `parameters_pkg`, alongside the existing `DATA_WIDTH`.
- Sub-module `fifo_req_slot`, parameter `W`. It provides the capture register, the pending flag, the clear input and a drop pulse output. It is instantiated twice: `W=DATA_WIDTH` for RF and `W=2*DATA_WIDTH` for ALU.

## Test plan
- RF only: `RF_RD_VLD` with 0x5A at edge 0, `FULL=0` → `W_INC`=1 for exactly one cycle and `WR_DATA`=0x5A written at edge 2. `RF_BUSY` is 1 from edge 0 until edge 2.
- ALU pair: `ALU_OUT`=0xBEEF → writes 0xEF at edge 2 and 0xBE at edge 3. `ALU_BUSY` clears at edge 3.
- Contention: RF=0x11 and ALU=0x2233 valid on the same edge → write order 0x11, 0x33, 0x22. Repeating the same stimulus → order 0x11, 0x33, 0x22 again, because `last` has become ALU.
- `FULL` between LO and HI: `FULL`=1 after the LO write for 5 cycles → `W_INC`=0 throughout. HI is written on the first edge after `FULL` falls. An RF request pending during the stall is written after HI.
- Drop: second `RF_RD_VLD` (0x77) while the first (0x66) is held with `FULL`=1 → only 0x66 is written. With `FIFO_ARB_DROP_CNT_EN` defined, `DROP_CNT`=1.
- Reset mid-pair: `RST`=0 after the LO write → next edge gives state `IDLE`, `W_INC`=0, both busy flags 0. No HI byte is written after release.

Source files
------------

// File: rtl/parameters_pkg.sv
// Shared widths and types for the FIFO write-side logic.
package parameters_pkg;

  localparam int unsigned DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    WR_RF,
    WR_ALU_LO,
    WR_ALU_HI
  } arb_state_e;

endpackage

// File: rtl/fifo_req_slot.sv
// One-deep request holding register with pending flag and drop detection.
module fifo_req_slot #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         vld,
  input  logic [W-1:0] data,
  input  logic         clr,
  output logic         pend,
  output logic [W-1:0] q,
  output logic         drop_c
);

  logic         pend_q;
  logic         pend_d;
  logic [W-1:0] data_q;
  logic [W-1:0] data_d;
  logic         take;

  // Capture when empty or when the held request is leaving this edge.
  always_comb begin
    take   = vld && (!pend_q || clr);
    pend_d = pend_q;
    data_d = data_q;
    if (take) begin
      pend_d = 1'b1;
      data_d = data;
    end else if (clr) begin
      pend_d = 1'b0;
    end
  end

  // Slot registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      data_q <= '0;
    end else begin
      pend_q <= pend_d;
      data_q <= data_d;
    end
  end

  assign pend   = pend_q;
  assign q      = data_q;
  assign drop_c = vld && pend_q && !clr;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port between RF bytes and
// atomic two-byte ALU results. Optional drop counter: FIFO_ARB_DROP_CNT_EN.
module fifo_wr_arbiter
  import parameters_pkg::*;
(
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RF_RD_DATA,
  input  logic                    RF_RD_VLD,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  input  logic                    FULL,
  output logic                    W_INC,
  output logic [DATA_WIDTH-1:0]   WR_DATA,
  output logic                    RF_BUSY,
  output logic                    ALU_BUSY
`ifdef FIFO_ARB_DROP_CNT_EN
  ,
  output logic [7:0]              DROP_CNT
`endif
);

  arb_state_e              state_q;
  arb_state_e              state_d;
  logic                    last_alu_q;
  logic                    last_alu_d;
  logic                    rf_pend;
  logic                    alu_pend;
  logic                    rf_clr;
  logic                    alu_clr;
  logic                    rf_drop_c;
  logic                    alu_drop_c;
  logic [DATA_WIDTH-1:0]   rf_data;
  logic [2*DATA_WIDTH-1:0] alu_data;

  // A slot is released on the edge its final byte is written.
  assign rf_clr  = (state_q == WR_RF) && !FULL;
  assign alu_clr = (state_q == WR_ALU_HI) && !FULL;

  fifo_req_slot #(.W(DATA_WIDTH)) u_rf_slot (
    .clk    (CLK),
    .rst_n  (RST),
    .vld    (RF_RD_VLD),
    .data   (RF_RD_DATA),
    .clr    (rf_clr),
    .pend   (rf_pend),
    .q      (rf_data),
    .drop_c (rf_drop_c)
  );

  fifo_req_slot #(.W(2 * DATA_WIDTH)) u_alu_slot (
    .clk    (CLK),
    .rst_n  (RST),
    .vld    (ALU_OUT_VLD),
    .data   (ALU_OUT),
    .clr    (alu_clr),
    .pend   (alu_pend),
    .q      (alu_data),
    .drop_c (alu_drop_c)
  );

  // Grant selection and FULL-gated byte sequencing.
  always_comb begin
    state_d    = state_q;
    last_alu_d = last_alu_q;
    case (state_q)
      IDLE: begin
        if (rf_pend && alu_pend) begin
          state_d = last_alu_q ? WR_RF : WR_ALU_LO;
        end else if (rf_pend) begin
          state_d = WR_RF;
        end else if (alu_pend) begin
          state_d = WR_ALU_LO;
        end
      end
      WR_RF: begin
        if (!FULL) begin
          state_d    = IDLE;
          last_alu_d = 1'b0;
        end
      end
      WR_ALU_LO: begin
        if (!FULL) begin
          state_d = WR_ALU_HI;
        end
      end
      WR_ALU_HI: begin
        if (!FULL) begin
          state_d    = IDLE;
          last_alu_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and round-robin history registers.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= IDLE;
      last_alu_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      last_alu_q <= last_alu_d;
    end
  end

  // Write data selected purely from state and held slot contents.
  always_comb begin
    WR_DATA = '0;
    case (state_q)
      WR_RF:     WR_DATA = rf_data;
      WR_ALU_LO: WR_DATA = alu_data[DATA_WIDTH-1:0];
      WR_ALU_HI: WR_DATA = alu_data[2*DATA_WIDTH-1:DATA_WIDTH];
      default:   WR_DATA = '0;
    endcase
  end

  assign W_INC    = (state_q != IDLE) && !FULL;
  assign RF_BUSY  = rf_pend;
  assign ALU_BUSY = alu_pend;

`ifdef FIFO_ARB_DROP_CNT_EN
  logic [7:0] drop_cnt_q;
  logic [7:0] drop_cnt_d;
  logic [8:0] drop_sum;

  // Saturating count of requests lost to a busy slot; both may drop at once.
  always_comb begin
    drop_sum   = {1'b0, drop_cnt_q} + 9'(rf_drop_c) + 9'(alu_drop_c);
    drop_cnt_d = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
  end

  // Drop counter register.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      drop_cnt_q <= 8'h00;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign DROP_CNT = drop_cnt_q;
`else
  logic unused_drops;
  assign unused_drops = rf_drop_c ^ alu_drop_c;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus random
// traffic compared against a byte-queue reference model.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        RST;
  logic [7:0]  RF_RD_DATA;
  logic        RF_RD_VLD;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VLD;
  logic        FULL;
  logic        W_INC;
  logic [7:0]  WR_DATA;
  logic        RF_BUSY;
  logic        ALU_BUSY;
`ifdef FIFO_ARB_DROP_CNT_EN
  logic [7:0]  DROP_CNT;
`endif

  int errs   = 0;
  int checks = 0;

  // Reference model: held requests plus the bytes still owed by the current grant.
  logic        m_rf_pend;
  logic [7:0]  m_rf_data;
  logic        m_alu_pend;
  logic [15:0] m_alu_data;
  logic        m_last_alu;
  logic        m_job_alu;
  logic [7:0]  m_job[$];
  int          m_drop;
  logic [7:0]  obs[$];

  fifo_wr_arbiter dut (
    .CLK         (clk),
    .RST         (RST),
    .RF_RD_DATA  (RF_RD_DATA),
    .RF_RD_VLD   (RF_RD_VLD),
    .ALU_OUT     (ALU_OUT),
    .ALU_OUT_VLD (ALU_OUT_VLD),
    .FULL        (FULL),
    .W_INC       (W_INC),
    .WR_DATA     (WR_DATA),
    .RF_BUSY     (RF_BUSY),
    .ALU_BUSY    (ALU_BUSY)
`ifdef FIFO_ARB_DROP_CNT_EN
    ,
    .DROP_CNT    (DROP_CNT)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_edge(input logic rst, input logic rv, input logic [7:0] rd,
                            input logic av, input logic [15:0] ad, input logic full);
    logic rf_clr;
    logic alu_clr;
    logic pick_alu;
    int   drops;
    logic [7:0] b;
    rf_clr  = 1'b0;
    alu_clr = 1'b0;
    drops   = 0;
    if (!rst) begin
      m_rf_pend  = 1'b0;
      m_rf_data  = 8'h00;
      m_alu_pend = 1'b0;
      m_alu_data = 16'h0000;
      m_last_alu = 1'b1;
      m_job.delete();
      m_drop     = 0;
      return;
    end
    if (m_job.size() != 0) begin
      if (!full) begin
        b = m_job.pop_front();
        if (m_job.size() == 0) begin
          if (m_job_alu) begin alu_clr = 1'b1; m_last_alu = 1'b1; end
          else begin rf_clr = 1'b1; m_last_alu = 1'b0; end
        end
      end
    end else if (m_rf_pend || m_alu_pend) begin
      pick_alu  = m_alu_pend && (!m_rf_pend || !m_last_alu);
      m_job_alu = pick_alu;
      if (pick_alu) begin
        m_job.push_back(m_alu_data[7:0]);
        m_job.push_back(m_alu_data[15:8]);
      end else begin
        m_job.push_back(m_rf_data);
      end
    end
    if (rv) begin
      if (!m_rf_pend || rf_clr) begin m_rf_pend = 1'b1; m_rf_data = rd; end
      else drops++;
    end else if (rf_clr) m_rf_pend = 1'b0;
    if (av) begin
      if (!m_alu_pend || alu_clr) begin m_alu_pend = 1'b1; m_alu_data = ad; end
      else drops++;
    end else if (alu_clr) m_alu_pend = 1'b0;
    m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
  endtask

  // One clock: drive at negedge, compare outputs, advance the model at posedge.
  task automatic cyc(input logic rst, input logic rv, input logic [7:0] rd,
                     input logic av, input logic [15:0] ad, input logic full);
    logic       e_winc;
    logic [7:0] e_data;
    RST = rst; RF_RD_VLD = rv; RF_RD_DATA = rd;
    ALU_OUT_VLD = av; ALU_OUT = ad; FULL = full;
    #1;
    e_winc = (m_job.size() != 0) && !full;
    e_data = (m_job.size() != 0) ? m_job[0] : 8'h00;
    checks++;
    if (W_INC !== e_winc) begin
      errs++; $display("FAIL w_inc t=%0t got=%b exp=%b", $time, W_INC, e_winc);
    end
    checks++;
    if (WR_DATA !== e_data) begin
      errs++; $display("FAIL wr_data t=%0t got=%h exp=%h", $time, WR_DATA, e_data);
    end
    checks++;
    if (RF_BUSY !== m_rf_pend || ALU_BUSY !== m_alu_pend) begin
      errs++; $display("FAIL busy t=%0t got=%b%b exp=%b%b", $time, RF_BUSY, ALU_BUSY,
                       m_rf_pend, m_alu_pend);
    end
`ifdef FIFO_ARB_DROP_CNT_EN
    checks++;
    if (DROP_CNT !== 8'(m_drop)) begin
      errs++; $display("FAIL drop_cnt t=%0t got=%0d exp=%0d", $time, DROP_CNT, m_drop);
    end
`endif
    if (rst && W_INC === 1'b1) obs.push_back(WR_DATA);
    @(posedge clk);
    model_edge(rst, rv, rd, av, ad, full);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic full);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, full);
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
    obs.delete();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (W_INC !== 1'b0 || WR_DATA !== 8'h00 || RF_BUSY !== 1'b0 || ALU_BUSY !== 1'b0) begin
      errs++; $display("FAIL reset_state got=%b %h %b %b exp=0 00 0 0", W_INC, WR_DATA, RF_BUSY, ALU_BUSY);
    end
`ifdef FIFO_ARB_DROP_CNT_EN
    checks++;
    if (DROP_CNT !== 8'h00) begin
      errs++; $display("FAIL reset_drop got=%0d exp=0", DROP_CNT);
    end
`endif
  endtask

  task automatic test_rf_only();
    do_reset();
    cyc(1'b1, 1'b1, 8'h5A, 1'b0, 16'h0000, 1'b0);
    idle(4, 1'b0);
    checks++;
    if (obs.size() != 1 || obs[0] !== 8'h5A) begin
      errs++; $display("FAIL rf_only writes got=%p exp='{5a}", obs);
    end
  endtask

  task automatic test_alu_pair();
    do_reset();
    cyc(1'b1, 1'b0, 8'h00, 1'b1, 16'hBEEF, 1'b0);
    idle(2, 1'b0);
    checks++;
    if (ALU_BUSY !== 1'b1 || W_INC !== 1'b1 || WR_DATA !== 8'hBE) begin
      errs++; $display("FAIL alu_hi_cycle got=%b %b %h exp=1 1 be", ALU_BUSY, W_INC, WR_DATA);
    end
    idle(3, 1'b0);
    checks++;
    if (obs.size() != 2 || obs[0] !== 8'hEF || obs[1] !== 8'hBE) begin
      errs++; $display("FAIL alu_pair writes got=%p exp='{ef,be}", obs);
    end
  endtask

  task automatic test_contention();
    logic [7:0] exp[$];
    do_reset();
    exp = '{8'h11, 8'h33, 8'h22, 8'h11, 8'h33, 8'h22};
    for (int r = 0; r < 2; r++) begin
      cyc(1'b1, 1'b1, 8'h11, 1'b1, 16'h2233, 1'b0);
      idle(8, 1'b0);
    end
    checks++;
    if (obs.size() != exp.size()) begin
      errs++; $display("FAIL contention count got=%0d exp=%0d", obs.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        checks++;
        if (obs[i] !== exp[i]) begin
          errs++; $display("FAIL contention byte%0d got=%h exp=%h", i, obs[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_full_stall();
    do_reset();
    cyc(1'b1, 1'b0, 8'h00, 1'b1, 16'hBEEF, 1'b0);
    idle(2, 1'b0);
    cyc(1'b1, 1'b1, 8'h44, 1'b0, 16'h0000, 1'b1);
    idle(4, 1'b1);
    idle(6, 1'b0);
    checks++;
    if (obs.size() != 3 || obs[0] !== 8'hEF || obs[1] !== 8'hBE || obs[2] !== 8'h44) begin
      errs++; $display("FAIL full_stall writes got=%p exp='{ef,be,44}", obs);
    end
  endtask

  task automatic test_drop();
    do_reset();
    cyc(1'b1, 1'b1, 8'h66, 1'b0, 16'h0000, 1'b1);
    cyc(1'b1, 1'b1, 8'h77, 1'b0, 16'h0000, 1'b1);
    idle(3, 1'b1);
    idle(5, 1'b0);
    checks++;
    if (obs.size() != 1 || obs[0] !== 8'h66) begin
      errs++; $display("FAIL drop writes got=%p exp='{66}", obs);
    end
`ifdef FIFO_ARB_DROP_CNT_EN
    checks++;
    if (DROP_CNT !== 8'd1) begin
      errs++; $display("FAIL drop_count got=%0d exp=1", DROP_CNT);
    end
`endif
  endtask

  task automatic test_reset_mid_pair();
    do_reset();
    cyc(1'b1, 1'b0, 8'h00, 1'b1, 16'h1234, 1'b0);
    idle(2, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
    #1;
    checks++;
    if (W_INC !== 1'b0 || RF_BUSY !== 1'b0 || ALU_BUSY !== 1'b0) begin
      errs++; $display("FAIL reset_mid got=%b %b %b exp=0 0 0", W_INC, RF_BUSY, ALU_BUSY);
    end
    idle(5, 1'b0);
    checks++;
    if (obs.size() != 1 || obs[0] !== 8'h34) begin
      errs++; $display("FAIL reset_mid writes got=%p exp='{34}", obs);
    end
  endtask

  task automatic test_random();
    logic rst;
    logic rv;
    logic av;
    logic full;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 499) != 0);
      rv   = ($urandom_range(0, 3) == 0);
      av   = ($urandom_range(0, 3) == 0);
      full = ($urandom_range(0, 9) < 3);
      cyc(rst, rv, 8'($urandom), av, 16'($urandom), full);
    end
  endtask

  initial begin
    RST = 1'b0; RF_RD_VLD = 1'b0; RF_RD_DATA = 8'h00;
    ALU_OUT_VLD = 1'b0; ALU_OUT = 16'h0000; FULL = 1'b0;
    model_edge(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
    test_reset();
    test_rf_only();
    test_alu_pair();
    test_contention();
    test_full_stall();
    test_drop();
    test_reset_mid_pair();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
